// File: rtl/ifetch_req_pkg.sv
// Shared types and constants for the instruction-fetch request stage.
package ifetch_req_pkg;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned INSTR_W = 32;

    localparam logic [XLEN-1:0] PCINIT_DEFAULT = 64'h0000_0000_8000_0000;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_REQ   = 2'd0;
    localparam fetch_state_t ST_HOLD  = 2'd1;
    localparam fetch_state_t ST_DRAIN = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               misalign;
    } fetch_data_t;

    // Instructions are 4-byte aligned; only the low two pc bits matter.
    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return pc_lo != 2'b00;
    endfunction

endpackage

// File: rtl/ifetch_req_outreg.sv
// Valid/ready output register towards decode, plus a one-entry skid buffer
// holding a response that arrived while decode was stalled.
module ifetch_req_outreg
    import ifetch_req_pkg::*;
#(
    parameter logic [XLEN-1:0] PCINIT = PCINIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    input  logic        load_i,
    input  logic        load_skid_i,
    input  logic        skid_we_i,
    input  fetch_data_t load_data_i,
    input  logic        ready_i,
    output logic        free_o,
    output logic        valid_o,
    output fetch_data_t data_o
);

    logic        valid_q, valid_d;
    fetch_data_t data_q,  data_d;
    fetch_data_t skid_q,  skid_d;

    assign free_o  = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // A flush kills both the visible entry and anything parked behind it.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        skid_d  = skid_q;
        if (flush_i) begin
            valid_d = 1'b0;
            skid_d  = '0;
        end else begin
            if (load_i) begin
                valid_d = 1'b1;
                data_d  = load_skid_i ? skid_q : load_data_i;
            end else if (valid_q && ready_i) begin
                valid_d = 1'b0;
            end
            if (skid_we_i) begin
                skid_d = load_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '{pc: PCINIT, instr: '0, misalign: 1'b0};
            skid_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/ifetch_req.sv
// Instruction fetch request stage: issues one bus read per pc, holds it until
// the response, and throttles the PC register through stallpc.
module ifetch_req
    import ifetch_req_pkg::*;
#(
    parameter bit              ALIGN_CHECK = 1'b1,
    parameter logic [XLEN-1:0] PCINIT      = PCINIT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [XLEN-1:0]    pc,
    output logic               stallpc,
    input  logic               flush,
    output logic               ireq_valid,
    output logic [XLEN-1:0]    ireq_addr,
    input  logic               iresp_data_ok,
    input  logic [INSTR_W-1:0] iresp_data,
    output logic               f_valid,
    output logic [XLEN-1:0]    f_pc,
    output logic [INSTR_W-1:0] f_instr,
    output logic               f_misalign,
    input  logic               d_ready
);

    fetch_state_t    state_q, state_d;
    logic            ireq_valid_q, ireq_valid_d;
    logic [XLEN-1:0] ireq_addr_q, ireq_addr_d;

    logic            stall_c;
    logic            misalign_c;
    logic            resp_c;
    logic            free_c;
    logic            load_c;
    logic            load_skid_c;
    logic            skid_we_c;
    fetch_data_t     load_data_c;
    fetch_data_t     out_data;

    assign misalign_c = ALIGN_CHECK && pc_misaligned(pc[1:0]);
    assign resp_c     = ireq_valid_q && iresp_data_ok;

    // Next-state and datapath control; flush takes priority in every state.
    always_comb begin
        state_d      = state_q;
        ireq_valid_d = ireq_valid_q;
        ireq_addr_d  = ireq_addr_q;
        stall_c      = 1'b1;
        load_c       = 1'b0;
        load_skid_c  = 1'b0;
        skid_we_c    = 1'b0;
        load_data_c  = '{pc: pc, instr: iresp_data, misalign: 1'b0};

        if (flush) begin
            stall_c = 1'b0;
            if (ireq_valid_q && !iresp_data_ok) begin
                state_d = ST_DRAIN;
            end else begin
                state_d      = ST_REQ;
                ireq_valid_d = 1'b0;
            end
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (misalign_c) begin
                        ireq_valid_d = 1'b0;
                        load_data_c  = '{pc: pc, instr: '0, misalign: 1'b1};
                        if (free_c) begin
                            load_c  = 1'b1;
                            stall_c = 1'b0;
                        end
                    end else if (resp_c) begin
                        ireq_valid_d = 1'b0;
                        if (free_c) begin
                            load_c  = 1'b1;
                            stall_c = 1'b0;
                        end else begin
                            skid_we_c = 1'b1;
                            state_d   = ST_HOLD;
                        end
                    end else begin
                        ireq_valid_d = 1'b1;
                        if (!ireq_valid_q) begin
                            ireq_addr_d = pc;
                        end
                    end
                end
                ST_HOLD: begin
                    if (free_c) begin
                        load_c      = 1'b1;
                        load_skid_c = 1'b1;
                        stall_c     = 1'b0;
                        state_d     = ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    // The response belongs to a flushed path and is dropped.
                    if (resp_c) begin
                        ireq_valid_d = 1'b0;
                        state_d      = ST_REQ;
                    end
                end
                default: begin
                    ireq_valid_d = 1'b0;
                    state_d      = ST_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_REQ;
            ireq_valid_q <= 1'b0;
            ireq_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            ireq_valid_q <= ireq_valid_d;
            ireq_addr_q  <= ireq_addr_d;
        end
    end

    ifetch_req_outreg #(
        .PCINIT (PCINIT)
    ) u_outreg (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush),
        .load_i      (load_c),
        .load_skid_i (load_skid_c),
        .skid_we_i   (skid_we_c),
        .load_data_i (load_data_c),
        .ready_i     (d_ready),
        .free_o      (free_c),
        .valid_o     (f_valid),
        .data_o      (out_data)
    );

    assign stallpc    = reset || stall_c;
    assign ireq_valid = ireq_valid_q;
    assign ireq_addr  = ireq_addr_q;
    assign f_pc       = out_data.pc;
    assign f_instr    = out_data.instr;
    assign f_misalign = out_data.misalign;

endmodule
